pwm_generator_3ch: RTL

//  Three-channel PWM generator downstream of the SPI memory manager. Consumes the 32-bit

---
 rtl/pwm_generator_3ch.sv | 63 ++++++
 1 files changed

// File: rtl/pwm_generator_3ch.sv
// pwm_generator_3ch: 3-channel PWM with shadowed config reloaded at period wrap.
// Define PWM_CENTER_ALIGNED_EN for an up/down counter; default is edge-aligned sawtooth.
module pwm_generator_3ch #(
  parameter int DATA_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] counter_value,
  input  logic [DATA_W-1:0] prescaler,
  input  logic [DATA_W-1:0] duty_cycle_1,
  input  logic [DATA_W-1:0] duty_cycle_2,
  input  logic [DATA_W-1:0] duty_cycle_3,
  input  logic              enable,
  output logic [2:0]        pwm_out,
  output logic              o_Period_Start
);
  logic [DATA_W-1:0] presc_cnt, cnt, cnt_nxt, per_sh, presc_sh;
  logic [DATA_W-1:0] duty_sh [3];
  logic tick, wrap;
  assign tick = enable && presc_cnt == presc_sh;
`ifdef PWM_CENTER_ALIGNED_EN
  logic dir, dir_nxt;
  // dir=1 means counting down; the wrap is the turnaround at zero
  always_comb begin
    wrap    = tick && (per_sh == '0 || (dir && cnt == '0));
    dir_nxt = !tick ? dir : per_sh == '0 ? 1'b0 : dir ? cnt != '0 : cnt == per_sh;
    cnt_nxt = !tick ? cnt : per_sh == '0 ? '0 : dir_nxt ? cnt - DATA_W'(1) : cnt + DATA_W'(1);
  end
`else
  always_comb begin
    wrap    = tick && cnt == per_sh;
    cnt_nxt = !tick ? cnt : wrap ? '0 : cnt + DATA_W'(1);
  end
`endif
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      presc_cnt      <= '0;
      cnt            <= '0;
      per_sh         <= '0;
      presc_sh       <= '0;
      duty_sh        <= '{default: '0};
      pwm_out        <= '0;
      o_Period_Start <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir            <= 1'b0;
`endif
    end else begin
      // while stopped the shadows track the inputs so a restart uses fresh config
      if (!enable || wrap) begin
        per_sh   <= counter_value;
        presc_sh <= prescaler;
        duty_sh  <= '{duty_cycle_1, duty_cycle_2, duty_cycle_3};
      end
      presc_cnt      <= (!enable || tick) ? '0 : presc_cnt + DATA_W'(1);
      cnt            <= enable ? cnt_nxt : '0;
      pwm_out        <= enable ? {cnt < duty_sh[2], cnt < duty_sh[1], cnt < duty_sh[0]} : 3'b000;
      o_Period_Start <= wrap;
`ifdef PWM_CENTER_ALIGNED_EN
      dir            <= enable && dir_nxt;
`endif
    end
  end
endmodule
